// File: rtl/pc_stack_unit_pkg.sv
// Shared encodings for the PIC16C5x program counter and return stack.
// The stack command encoding is the one the control unit drives.
package pc_stack_unit_pkg;

  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10,
    STK_RSVD = 2'b11
  } stk_cmd_e;

  localparam logic [7:0] PCL_ADDR = 8'h02;

  function automatic logic is_stk_cmd(input logic [1:0] cmd, input stk_cmd_e kind);
    return cmd == kind;
  endfunction

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// Shift-register return stack: level 0 is top of stack, pop copies the bottom
// level down (PIC behaviour), depth saturates and misuse sets sticky flags.
module pc_stack_unit_return_stack
  import pc_stack_unit_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_tos,
  output logic [1:0]       o_depth,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_level [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_level[i] <= '0;
    end else if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) r_level[i] <= r_level[i+1];
    end else if (i_push) begin
      r_level[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_level[i] <= r_level[i-1];
    end
  end

  // Pop has priority; the parent never asserts both, but keep it deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_pop) begin
      if (r_depth == '0) r_unf <= 1'b1;
      else               r_depth <= r_depth - DW'(1);
    end else if (i_push) begin
      if (r_depth == DW'(DEPTH)) r_ovf <= 1'b1;
      else                       r_depth <= r_depth + DW'(1);
    end
  end

  assign o_tos   = r_level[0];
  assign o_depth = (r_depth > DW'(3)) ? 2'd3 : r_depth[1:0];
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: rtl/pc_stack_unit.sv
// PIC16C5x program counter with page merge, load priority mux and a
// return stack for CALL/RETLW.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 11,
  parameter int STACK_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          stackCommand,
  input  logic                incEn,
  input  logic                gotoEn,
  input  logic [11:0]         instIn,
  input  logic                pclWe,
  input  logic [7:0]          pclData,
  input  logic [1:0]          pa,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic [PC_WIDTH-1:0] tos,
  output logic [1:0]          stackDepth,
  output logic                stkOverflow,
  output logic                stkUnderflow
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_goto_tgt;
  logic [PC_WIDTH-1:0] w_call_tgt;
  logic [PC_WIDTH-1:0] w_pcl_tgt;
  logic [PC_WIDTH-1:0] w_tos;
  logic                w_push;
  logic                w_pop;
  logic                w_unused;

  assign w_pop  = is_stk_cmd(stackCommand, STK_POP);
  assign w_push = is_stk_cmd(stackCommand, STK_PUSH);

  // Page bits fill whatever lies above the 9-bit in-page address.
  generate
    if (PC_WIDTH > 9) begin : g_page
      localparam int PW = PC_WIDTH - 9;
      assign w_goto_tgt = {pa[PW-1:0], instIn[8:0]};
      assign w_call_tgt = {pa[PW-1:0], 1'b0, instIn[7:0]};
      assign w_pcl_tgt  = {pa[PW-1:0], 1'b0, pclData};
    end else begin : g_nopage
      assign w_goto_tgt = instIn[8:0];
      assign w_call_tgt = {1'b0, instIn[7:0]};
      assign w_pcl_tgt  = {1'b0, pclData};
    end
  endgenerate

  assign w_unused = ^{instIn[11:9], pa};

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_pop)       w_pc_nxt = w_tos;
    else if (w_push) w_pc_nxt = w_call_tgt;
    else if (gotoEn) w_pc_nxt = w_goto_tgt;
    else if (pclWe)  w_pc_nxt = w_pcl_tgt;
    else if (incEn)  w_pc_nxt = r_pc + PC_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= '1;
    else        r_pc <= w_pc_nxt;
  end

  pc_stack_unit_return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_pc),
    .o_tos   (w_tos),
    .o_depth (stackDepth),
    .o_ovf   (stkOverflow),
    .o_unf   (stkUnderflow)
  );

  assign pcOut = r_pc;
  assign tos   = w_tos;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed steps queue expected state,
// a monitor drains the queue and compares against the DUT outputs.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  stackCommand;
  logic        incEn;
  logic        gotoEn;
  logic [11:0] instIn;
  logic        pclWe;
  logic [7:0]  pclData;
  logic [1:0]  pa;
  logic [10:0] pcOut;
  logic [10:0] tos;
  logic [1:0]  stackDepth;
  logic        stkOverflow;
  logic        stkUnderflow;

  typedef struct {
    string       name;
    logic [10:0] pc;
    logic [10:0] tos;
    logic [1:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event mon_ev;

  pc_stack_unit #(.PC_WIDTH(11), .STACK_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stackCommand (stackCommand),
    .incEn        (incEn),
    .gotoEn       (gotoEn),
    .instIn       (instIn),
    .pclWe        (pclWe),
    .pclData      (pclData),
    .pa           (pa),
    .pcOut        (pcOut),
    .tos          (tos),
    .stackDepth   (stackDepth),
    .stkOverflow  (stkOverflow),
    .stkUnderflow (stkUnderflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string fld, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, fld, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pcOut", int'(pcOut), int'(e.pc));
        chk(e.name, "tos", int'(tos), int'(e.tos));
        chk(e.name, "depth", int'(stackDepth), int'(e.depth));
        chk(e.name, "ovf", int'(stkOverflow), int'(e.ovf));
        chk(e.name, "unf", int'(stkUnderflow), int'(e.unf));
      end
    end
  end

  task automatic expect_st(input string name, input logic [10:0] p, input logic [10:0] t,
                           input logic [1:0] d, input logic o, input logic u);
    exp_t e;
    e.name = name; e.pc = p; e.tos = t; e.depth = d; e.ovf = o; e.unf = u;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    stackCommand = 2'b00; incEn = 1'b0; gotoEn = 1'b0;
    instIn = 12'h000; pclWe = 1'b0; pclData = 8'h00; pa = 2'b00;
  endtask

  // One clock of stimulus; the expected state is queued after the edge and
  // the monitor checks it on the following falling edge.
  task automatic step(input string name, input logic [1:0] cmd, input logic inc,
                      input logic gto, input logic [11:0] inst, input logic we,
                      input logic [7:0] pd, input logic [1:0] pg,
                      input logic [10:0] p, input logic [10:0] t,
                      input logic [1:0] d, input logic o, input logic u);
    stackCommand = cmd; incEn = inc; gotoEn = gto;
    instIn = inst; pclWe = we; pclData = pd; pa = pg;
    @(posedge clk);
    #1;
    idle();
    expect_st(name, p, t, d, o, u);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 11'h7FF, 11'h000, 2'd0, 1'b0, 1'b0);
    ->mon_ev;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    //      name        cmd   inc  gto  inst     we   pd     pa     pc       tos      d  o  u
    step("inc_wrap",  2'b00,1'b1,1'b0,12'h000,1'b0,8'h00,2'b00,11'h000,11'h000,2'd0,0,0);
    step("inc_1",     2'b00,1'b1,1'b0,12'h000,1'b0,8'h00,2'b00,11'h001,11'h000,2'd0,0,0);
    step("inc_2",     2'b00,1'b1,1'b0,12'h000,1'b0,8'h00,2'b00,11'h002,11'h000,2'd0,0,0);

    step("pcl_010",   2'b00,1'b0,1'b0,12'h000,1'b1,8'h10,2'b00,11'h010,11'h000,2'd0,0,0);
    step("call_a5",   2'b01,1'b0,1'b0,12'h9A5,1'b0,8'h00,2'b01,11'h2A5,11'h010,2'd1,0,0);
    step("ret_a5",    2'b10,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h010,11'h000,2'd0,0,0);

    step("goto_100",  2'b00,1'b0,1'b1,12'h100,1'b0,8'h00,2'b00,11'h100,11'h000,2'd0,0,0);
    step("push_1",    2'b01,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h000,11'h100,2'd1,0,0);
    step("goto_200",  2'b00,1'b0,1'b1,12'h000,1'b0,8'h00,2'b01,11'h200,11'h100,2'd1,0,0);
    step("push_2",    2'b01,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h000,11'h200,2'd2,0,0);
    step("goto_300",  2'b00,1'b0,1'b1,12'h100,1'b0,8'h00,2'b01,11'h300,11'h200,2'd2,0,0);
    step("push_ovf",  2'b01,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h000,11'h300,2'd2,1,0);
    step("pop_1",     2'b10,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h300,11'h200,2'd1,1,0);
    step("pop_2",     2'b10,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h200,11'h200,2'd0,1,0);
    step("pop_unf",   2'b10,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h200,11'h200,2'd0,1,1);

    step("goto_5ff",  2'b00,1'b0,1'b1,12'hBFF,1'b0,8'h00,2'b10,11'h5FF,11'h200,2'd0,1,1);
    step("pcl_07e",   2'b00,1'b0,1'b0,12'h000,1'b1,8'h7E,2'b00,11'h07E,11'h200,2'd0,1,1);

    step("goto_inc",  2'b00,1'b1,1'b1,12'h123,1'b0,8'h00,2'b00,11'h123,11'h200,2'd0,1,1);
    step("push_3",    2'b01,1'b0,1'b0,12'h000,1'b0,8'h00,2'b00,11'h000,11'h123,2'd1,1,1);
    step("pop_goto",  2'b10,1'b0,1'b1,12'h0FF,1'b0,8'h00,2'b00,11'h123,11'h200,2'd0,1,1);
    step("rsvd_inc",  2'b11,1'b1,1'b0,12'h000,1'b0,8'h00,2'b00,11'h124,11'h200,2'd0,1,1);

    // Reset asserted between edges while a PUSH is presented.
    stackCommand = 2'b01; instIn = 12'h055;
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("rst_async", 11'h7FF, 11'h000, 2'd0, 1'b0, 1'b0);
    ->mon_ev;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step("post_rst",  2'b00,1'b1,1'b0,12'h000,1'b0,8'h00,2'b00,11'h000,11'h000,2'd0,0,0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
